piece_render_engine: RTL

//  Parametrised pixel-enable generator for the falling piece: given the VGA scan address, piece origin and

---
 rtl/piece_render_engine.sv | 123 ++++++++++++
 1 files changed

// File: rtl/piece_render_engine.sv
// piece_render_engine: per-pixel enable/edge/colour for the falling piece over a GRID x GRID mask,
// with piece state shadowed once per frame and a 2-cycle scan-address-to-output pipeline.
module piece_render_engine #(
  parameter int ADDR_W = 11,
  parameter int GRID = 4,
  parameter int CELL = 20,
  parameter int INSET = 1,
  parameter int EDGE_W = 1,
  parameter int COLOR_W = 12,
  parameter bit SHADOW_EN = 1'b1,
  parameter int IDX_W = (GRID * GRID > 1) ? $clog2(GRID * GRID) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      col_addr_sig,
  input  logic [ADDR_W-1:0]      row_addr_sig,
  input  logic                   frame_start,
  input  logic [ADDR_W-1:0]      piece_h,
  input  logic [ADDR_W-1:0]      piece_v,
  input  logic [GRID*GRID-1:0]   piece_mask,
  input  logic [COLOR_W-1:0]     piece_color,
  input  logic                   piece_visible,
  output logic                   enable_piece,
  output logic                   edge_o,
  output logic [COLOR_W-1:0]     color_o,
  output logic [IDX_W-1:0]       cell_idx_o
);
  localparam int W = ADDR_W + 1;
  localparam int SPAN = GRID * CELL;
  localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam int GW = (GRID > 1) ? $clog2(GRID) : 1;
  localparam int LO = INSET;
  localparam int HI = CELL - 1 - INSET;
  localparam int ELO = INSET + EDGE_W;
  localparam int EHI = CELL - 1 - INSET - EDGE_W;

  typedef struct packed {
    logic          in;
    logic [GW-1:0] c;
    logic [CW-1:0] off;
  } axis_t;

  logic [ADDR_W-1:0]    sh_h, sh_v;
  logic [GRID*GRID-1:0] sh_mask;
  logic [COLOR_W-1:0]   sh_color;
  logic                 sh_vis;
  logic                 load;

  assign load = frame_start || !SHADOW_EN;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_h     <= '0;
      sh_v     <= '0;
      sh_mask  <= '0;
      sh_color <= '0;
      sh_vis   <= 1'b0;
    end else if (load) begin
      sh_h     <= piece_h;
      sh_v     <= piece_v;
      sh_mask  <= piece_mask;
      sh_color <= piece_color;
      sh_vis   <= piece_visible;
    end

  // Offset is taken one bit wider than the address so an origin near the top of the range clips instead of wrapping
  function automatic axis_t axis_split(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] o);
    logic [W-1:0] d;
    axis_split = '0;
    d = {1'b0, a} - {1'b0, o};
    axis_split.in = (a >= o) && (d < W'(SPAN));
    for (int k = 1; k < GRID; k++)
      if (d >= W'(k * CELL)) axis_split.c = GW'(k);
    axis_split.off = CW'(d - W'(axis_split.c * CELL));
    return axis_split;
  endfunction

  axis_t            ax, ay;
  logic [IDX_W-1:0] idx;

  assign ax  = axis_split(col_addr_sig, sh_h);
  assign ay  = axis_split(row_addr_sig, sh_v);
  assign idx = IDX_W'(ay.c * GRID + ax.c);

  logic               s1_occ;
  logic [CW-1:0]      s1_ox, s1_oy;
  logic [IDX_W-1:0]   s1_idx;
  logic [COLOR_W-1:0] s1_color;

  // Mask bit and colour are captured with the address so a frame_start on this pixel cannot mix old and new state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_occ   <= 1'b0;
      s1_ox    <= '0;
      s1_oy    <= '0;
      s1_idx   <= '0;
      s1_color <= '0;
    end else begin
      s1_occ   <= ax.in && ay.in && sh_vis && sh_mask[idx];
      s1_ox    <= ax.off;
      s1_oy    <= ay.off;
      s1_idx   <= idx;
      s1_color <= sh_color;
    end

  logic in_cell, on_edge;

  assign in_cell = s1_occ && s1_ox >= CW'(LO) && s1_ox <= CW'(HI) && s1_oy >= CW'(LO) && s1_oy <= CW'(HI);
  assign on_edge = s1_ox < CW'(ELO) || s1_ox > CW'(EHI) || s1_oy < CW'(ELO) || s1_oy > CW'(EHI);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      enable_piece <= 1'b0;
      edge_o       <= 1'b0;
      color_o      <= '0;
      cell_idx_o   <= '0;
    end else begin
      enable_piece <= in_cell;
      edge_o       <= in_cell && on_edge;
      color_o      <= in_cell ? s1_color : '0;
      cell_idx_o   <= in_cell ? s1_idx : '0;
    end
endmodule
